// File: rtl/lcd_byte_writer.sv
// Purpose: writes one byte (or only its upper nibble) to an HD44780-style LCD
//          over the 4-bit bus. Each nibble gets a setup, E pulse and hold window,
//          the two nibbles are separated by a gap, and the byte is followed by a
//          post-write wait (short or long). One request at a time; a request
//          arriving while busy is dropped.
// Ports:
//   Clock, Reset            - system clock, asynchronous active-low reset
//   iData/iRS               - byte and register select, captured at acceptance
//   iNibbleOnly/iLongWait   - send upper nibble only / use the long post-write wait
//   iValid/oReady           - request handshake (accepted when both are 1)
//   oDone                   - one-cycle pulse once the transfer and its wait end
//   oLCD_Enabled            - E pin (registered)
//   oLCD_RegisterSelect     - RS pin
//   oLCD_Data               - DB[7:4]
//   oLCD_ReadWrite          - tied 0 (write only)
//   oLCD_StrataFlashControl - tied 1 (StrataFlash disabled)
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned ENABLE_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned BYTE_GAP_CYC   = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iNibbleOnly,
  input  logic       iLongWait,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_StrataFlashControl,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CNT_W = 17;

  // Counter load values: a state lasting N cycles starts at N-1 and leaves at 0.
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ENABLE = CNT_W'(ENABLE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_BYTE   = CNT_W'(BYTE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG   = CNT_W'(LONG_WAIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP,
    SETUP_L,
    PULSE_L,
    HOLD_L,
    WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_wait_ld;
  logic             w_cnt_zero;
  logic             w_accept;

  // Request captured at acceptance
  logic [3:0] r_lo;
  logic       r_nib_only;
  logic       r_long;

  // Registered pin / status outputs
  logic       r_e;
  logic       r_rs;
  logic [3:0] r_data;
  logic       r_ready;
  logic       r_done;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_wait_ld  = r_long ? LD_LONG : LD_BYTE;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and timing counter; every timed state leaves when the counter hits 0
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (iValid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP_H;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      SETUP_H: begin
        if (w_cnt_zero) begin
          w_state_nxt = PULSE_H;
          w_cnt_nxt   = LD_ENABLE;
        end
      end
      PULSE_H: begin
        if (w_cnt_zero) begin
          w_state_nxt = HOLD_H;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      HOLD_H: begin
        if (w_cnt_zero) begin
          if (r_nib_only) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = w_wait_ld;
          end else begin
            w_state_nxt = GAP;
            w_cnt_nxt   = LD_GAP;
          end
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = SETUP_L;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      SETUP_L: begin
        if (w_cnt_zero) begin
          w_state_nxt = PULSE_L;
          w_cnt_nxt   = LD_ENABLE;
        end
      end
      PULSE_L: begin
        if (w_cnt_zero) begin
          w_state_nxt = HOLD_L;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      HOLD_L: begin
        if (w_cnt_zero) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = w_wait_ld;
        end
      end
      WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_e        <= 1'b0;
      r_rs       <= 1'b0;
      r_data     <= 4'h0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_lo       <= 4'h0;
      r_nib_only <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_e     <= (w_state_nxt == PULSE_H) || (w_state_nxt == PULSE_L);
      r_ready <= (w_state_nxt == IDLE);
      r_done  <= (r_state == WAIT) && (w_state_nxt == IDLE);
      if (w_accept) begin
        r_data     <= iData[7:4];
        r_rs       <= iRS;
        r_lo       <= iData[3:0];
        r_nib_only <= iNibbleOnly;
        r_long     <= iLongWait;
      end else if ((r_state == GAP) && (w_state_nxt == SETUP_L)) begin
        r_data <= r_lo;
      end
    end
  end

  assign oReady                  = r_ready;
  assign oDone                   = r_done;
  assign oLCD_Enabled            = r_e;
  assign oLCD_RegisterSelect     = r_rs;
  assign oLCD_Data               = r_data;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter SETUP_CYC, 2: cycles the data and RS are stable before E rises (40 ns at 50 MHz).
REQ-002 Parameter ENABLE_CYC, 12: cycles E is held high (240 ns).
REQ-003 Parameter HOLD_CYC, 1: cycles the data and RS are held after E falls.
REQ-004 Parameter NIBBLE_GAP_CYC, 50: cycles between the upper-nibble hold and the lower-nibble setup (1 us).
REQ-005 Parameter BYTE_GAP_CYC, 2000: post-byte wait in cycles (40 us).
REQ-006 Parameter LONG_WAIT_CYC, 82000: post-byte wait in cycles when a long wait is requested (1.64 ms); every parameter SHALL be >=1 and fit in 17 bits.
REQ-007 Clock  in  1  single system clock; all state updates on the rising edge.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 iData  in  8  byte to write; the upper nibble is sent first.
REQ-010 iRS  in  1  register select for the byte: 0 = command, 1 = data.
REQ-011 iNibbleOnly  in  1  1 = send only iData[7:4] (used for init sequences).
REQ-012 iLongWait  in  1  1 = use LONG_WAIT_CYC instead of BYTE_GAP_CYC.
REQ-013 iValid  in  1  request strobe.
REQ-014 oReady  out  1  1 = idle and able to accept a request.
REQ-015 oDone  out  1  one-cycle pulse when a transfer, including its wait, is complete.
REQ-016 oLCD_Enabled  out  1  LCD E pin.
REQ-017 oLCD_RegisterSelect  out  1  LCD RS pin.
REQ-018 oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled).
REQ-019 oLCD_ReadWrite  out  1  constant 0 (write only).
REQ-020 oLCD_Data  out  4  LCD DB[7:4].

Function
REQ-021 A request SHALL be accepted on a rising edge where iValid=1 and oReady=1.
REQ-022 At acceptance, iData, iRS, iNibbleOnly and iLongWait SHALL be registered; later changes to these inputs SHALL have no effect on the transfer.
REQ-023 iValid asserted while oReady=0 SHALL be ignored, with no queuing.
REQ-024 The state machine SHALL have the states IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L and WAIT.
REQ-025 Each timed state SHALL last exactly its parameter in cycles, using one down-counter of at least 17 bits.
REQ-026 On acceptance, the block SHALL go IDLE->SETUP_H, with oLCD_Data=iData[7:4] and RS=iRS valid from the acceptance edge.
REQ-027 Transitions: SETUP_H->PULSE_H->HOLD_H->GAP->SETUP_L->PULSE_L->HOLD_L->WAIT->IDLE.
REQ-028 If iNibbleOnly was registered as 1, HOLD_H SHALL go directly to WAIT.
REQ-029 oLCD_Data SHALL switch to the low nibble on entry to SETUP_L and be stable throughout SETUP_L, PULSE_L and HOLD_L.
REQ-030 oLCD_Enabled SHALL be 1 only in PULSE_H and PULSE_L, and SHALL be driven from a register (glitch-free).
REQ-031 The WAIT length SHALL be LONG_WAIT_CYC if iLongWait was registered as 1, otherwise BYTE_GAP_CYC.
REQ-032 oReady SHALL be 1 exactly when the state is IDLE.
REQ-033 oDone SHALL be 1 for exactly the first IDLE cycle after WAIT.
REQ-034 A new request accepted during the oDone cycle SHALL be legal (back-to-back operation).
REQ-035 Latency from the acceptance edge to oDone high SHALL be 2*(SETUP+ENABLE+HOLD)+NIBBLE_GAP+wait cycles, which is 2080 with the defaults.
REQ-036 In nibble-only mode, that latency SHALL be SETUP+ENABLE+HOLD+wait cycles, which is 2015 with the defaults.
REQ-037 In IDLE, oLCD_Data and RS SHALL hold the last driven values.

Reset
REQ-038 While Reset=0, the block SHALL asynchronously return to IDLE with a counter value of 0.
REQ-039 While Reset=0, the outputs SHALL be: oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oLCD_ReadWrite=0, oLCD_StrataFlashControl=1, oReady=1, oDone=0.
REQ-040 A reset asserted mid-transfer, including during PULSE_*, SHALL drop E immediately, abort the transfer and produce no oDone.
REQ-041 Operation SHALL resume on the first rising edge after Reset returns to 1.

Verification
REQ-042 Full byte: iData=0x41, iRS=1, defaults -> E high for 12 cycles with Data=0x4, then 50 gap cycles, then E high for 12 cycles with Data=0x1; RS=1 throughout; oDone pulses 2080 cycles after acceptance.
REQ-043 Nibble-only: iData=0x30, iRS=0, iNibbleOnly=1 -> exactly one E pulse with Data=0x3; oDone after 2015 cycles.
REQ-044 Long wait: iData=0x01, iLongWait=1 -> oDone after 2*15+50+82000=82080 cycles.
REQ-045 Busy ignore: iValid held high throughout two back-to-back bytes 0x28 then 0x0C -> the second byte is accepted in the oDone cycle; exactly 4 E pulses; iData changes mid-transfer do not alter the nibbles.
REQ-046 Reset mid-pulse: Reset=0 during the 6th PULSE_H cycle -> E=0 within the same cycle, no oDone; after release oReady=1 and a new byte 0x80 completes normally.
REQ-047 Invariants checked every cycle: RW=0, SF=1, Data and RS stable whenever E=1, and E never high for 2 consecutive pulses without an intervening low.
